mem_model_2p_pipe: RTL and testbench

Simple-dual-port (1W1R) SRAM behavioural model for the SRAM group. It provides byte-enabled writes, a configurable read pipeline with a valid strobe, and a self-clearing init sequencer that replaces the per-entry asynchronous reset of the single-port model. It is the drop-in storage primitive for vector-cache data and tag arrays that need concurrent fill and lookup.

---
 rtl/mem_model_2p_pipe.sv | 101 ++++++++++
 tb/tb_mem_model_2p_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_model_2p_pipe.sv
// 1W1R SRAM model: byte-enabled writes, RD_LATENCY read pipe, self-clearing init.
// MEM_MODEL_2P_WR_BYPASS_EN selects write-first collisions (default read-first).
module mem_model_2p_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  run;
  logic                  rd_go;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  assign run   = (state_q == RUN);
  assign rd_go = run & rd_en;

  // Storage has no reset; INIT sweeps zeros through it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i+:8] <= wr_data[8*i+:8];
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_addr];
`ifdef MEM_MODEL_2P_WR_BYPASS_EN
    if (run && wr_en && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i+:8] = wr_data[8*i+:8];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_go;
      if (rd_go) dat_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_data   = dat_q[RD_LATENCY-1];
  assign rd_valid  = vld_q[RD_LATENCY-1];
  assign init_done = run;

endmodule

// File: tb/tb_mem_model_2p_pipe.sv
// Directed bench: four instances (RD_LATENCY 1..4) share one stimulus stream.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_mem_model_2p_pipe;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rdd [NI];
  logic          rdv [NI];
  logic          idn [NI];

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] ra [16];
  logic [DW-1:0] re [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_model_2p_pipe #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RD_LATENCY(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_be    (wr_be),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rdd[g]),
      .rd_valid (rdv[g]),
      .init_done(idn[g])
    );
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s vld L%0d", tag, i + 1), {31'b0, rdv[i]}, 32'd0);
    end
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [3:0] be,
                        input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Released at a falling edge; init_done must rise after edge 16.
  task automatic init_wait(input string tag);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk_quiet($sformatf("%s k%0d", tag, k));
      if (k == 15) chk({tag, " idn early"}, {31'b0, idn[0]}, 32'd0);
      if (k == 16) begin
        for (int i = 0; i < NI; i++)
          chk($sformatf("%s idn L%0d", tag, i + 1), {31'b0, idn[i]}, 32'd1);
      end
      rd_en   = (k < 15);
      rd_addr = AW'(k);
    end
  endtask

  // Back-to-back reads of ra[0..n-1]; checks each latency's delivery window.
  task automatic run_reads(input string tag, input int n);
    for (int j = 0; j <= n + 4; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        int lat = i + 1;
        if (j >= lat && j < lat + n) begin
          chk($sformatf("%s v L%0d j%0d", tag, lat, j), {31'b0, rdv[i]}, 32'd1);
          chk($sformatf("%s d L%0d j%0d", tag, lat, j), rdd[i], re[j-lat]);
        end else if (j >= lat + n) begin
          chk($sformatf("%s v L%0d j%0d", tag, lat, j), {31'b0, rdv[i]}, 32'd0);
          chk($sformatf("%s hold L%0d j%0d", tag, lat, j), rdd[i], re[n-1]);
        end else begin
          chk($sformatf("%s v L%0d j%0d", tag, lat, j), {31'b0, rdv[i]}, 32'd0);
        end
      end
      rd_en   = (j < n);
      rd_addr = (j < n) ? ra[j] : '0;
    end
  endtask

  initial begin
    logic [DW-1:0] col_exp;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst data L%0d", i + 1), rdd[i], 32'd0);
      chk($sformatf("rst vld L%0d", i + 1), {31'b0, rdv[i]}, 32'd0);
      chk($sformatf("rst idn L%0d", i + 1), {31'b0, idn[i]}, 32'd0);
    end

    init_wait("init");
    for (int k = 0; k < 16; k++) begin ra[k] = AW'(k); re[k] = '0; end
    run_reads("zero", 16);

    for (int k = 0; k < 8; k++) write1(AW'(k), 4'hf, 32'hC0DE_0000 | k);
    for (int k = 0; k < 8; k++) begin ra[k] = AW'(k); re[k] = 32'hC0DE_0000 | k; end
    run_reads("sweep", 8);

    write1(4'd5, 4'hf, 32'hFFFF_FFFF);
    write1(4'd5, 4'h1, 32'h0000_0000);
    ra[0] = 4'd5; re[0] = 32'hFFFF_FF00;
    run_reads("be", 1);

    write1(4'd3, 4'hf, 32'h1111_1111);
`ifdef MEM_MODEL_2P_WR_BYPASS_EN
    col_exp = 32'h2222_2222;
`else
    col_exp = 32'h1111_1111;
`endif
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'hf; wr_data = 32'h2222_2222;
    rd_en = 1'b1; rd_addr = 4'd3;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("col v L%0d j%0d", i + 1, j), {31'b0, rdv[i]},
            {31'b0, (j == i + 1)});
        if (j >= i + 1) chk($sformatf("col d L%0d j%0d", i + 1, j), rdd[i], col_exp);
      end
    end
    ra[0] = 4'd3; re[0] = 32'h2222_2222;
    run_reads("after col", 1);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_en = 1'b1; rd_addr = AW'(k);
    end
    @(negedge clk);
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid vld L%0d", i + 1), {31'b0, rdv[i]}, 32'd0);
      chk($sformatf("mid data L%0d", i + 1), rdd[i], 32'd0);
      chk($sformatf("mid idn L%0d", i + 1), {31'b0, idn[i]}, 32'd0);
    end
    repeat (2) begin
      @(negedge clk);
      chk_quiet("mid hold");
    end
    init_wait("reinit");
    for (int k = 0; k < 16; k++) begin ra[k] = AW'(k); re[k] = '0; end
    run_reads("rezero", 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
